// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, head/payload field positions and the eject FSM states.
package noc_pkg;

  localparam int NOC_FLIT_W = 16;
  localparam int NODE_W     = 2;
  localparam int LEN_W      = 4;
  localparam int PAYLOAD_W  = 14;
  localparam int CSUM_W     = 6;

  localparam int TYPE_HI = 15;
  localparam int TYPE_LO = 14;
  localparam int SRC_HI  = 13;
  localparam int SRC_LO  = 12;
  localparam int DST_HI  = 11;
  localparam int DST_LO  = 10;
  localparam int LEN_HI  = 9;
  localparam int LEN_LO  = 6;
  localparam int CSUM_HI = 5;
  localparam int CSUM_LO = 0;

  typedef enum logic [1:0] {
    FT_IDLE = 2'b00,
    FT_HEAD = 2'b01,
    FT_BODY = 2'b10,
    FT_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } eject_state_e;

  function automatic flit_type_e flit_type(input logic [NOC_FLIT_W-1:0] f);
    return flit_type_e'(f[TYPE_HI:TYPE_LO]);
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with combinational head output; DEPTH must be a power of two so pointers wrap naturally.
module noc_sync_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/noc_eject_unit.sv
// Mesh node receive port: filters by destination, reassembles payload into a FIFO, reports packet status.
// Optional build macro NOC_EJECT_CHECKSUM_EN enables the head [5:0] XOR checksum check at a good tail.
module noc_eject_unit
  import noc_pkg::*;
#(
  parameter int NODE_ID    = 0,
  parameter int FLIT_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [FLIT_W-1:0]    in_flit,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [PAYLOAD_W-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 pkt_done,
  output logic [NODE_W-1:0]    pkt_src,
  output logic [LEN_W-1:0]     pkt_len,
  output logic                 pkt_err,
  output logic                 ready
);

  eject_state_e state_q, state_d;

  logic [NODE_W-1:0] rsrc_q, rsrc_d;
  logic [LEN_W-1:0]  rlen_q, rlen_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              done_q, done_d;
  logic [NODE_W-1:0] src_q, src_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              err_q, err_d;

  logic                          accept, push, fifo_full, fifo_empty, csum_bad;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  flit_type_e                    ftype;
  logic [NODE_W-1:0]             f_src, f_dst;
  logic [LEN_W-1:0]              f_len;
  logic [PAYLOAD_W-1:0]          f_pay;
  logic                          dst_hit;

  assign ftype   = flit_type(in_flit);
  assign f_src   = in_flit[SRC_HI:SRC_LO];
  assign f_dst   = in_flit[DST_HI:DST_LO];
  assign f_len   = in_flit[LEN_HI:LEN_LO];
  assign f_pay   = in_flit[PAYLOAD_W-1:0];
  assign dst_hit = (f_dst == NODE_W'(NODE_ID));
  assign cnt_inc = cnt_q + 1'b1;

  // DROP swallows the rest of a packet regardless of FIFO space.
  assign in_ready = (state_q == ST_DROP) ? 1'b1 : !fifo_full;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (ftype == FT_HEAD && f_len != '0) state_d = dst_hit ? ST_RECV : ST_DROP;
        end
        ST_RECV: begin
          if (ftype == FT_BODY && cnt_inc == rlen_q)        state_d = ST_DROP;
          else if (ftype == FT_TAIL || ftype == FT_HEAD)   state_d = ST_IDLE;
        end
        ST_DROP: begin
          if (ftype == FT_TAIL) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    push   = 1'b0;
    done_d = 1'b0;
    src_d  = src_q;
    len_d  = len_q;
    err_d  = err_q;
    rsrc_d = rsrc_q;
    rlen_d = rlen_q;
    cnt_d  = cnt_q;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (ftype == FT_HEAD) begin
            rsrc_d = f_src;
            rlen_d = f_len;
            cnt_d  = '0;
            if (f_len == '0) begin
              done_d = 1'b1;
              src_d  = f_src;
              len_d  = '0;
              err_d  = !dst_hit;
            end
          end
        end
        ST_RECV: begin
          if (ftype == FT_BODY && cnt_inc != rlen_q) begin
            push  = 1'b1;
            cnt_d = cnt_inc;
          end else if (ftype == FT_TAIL) begin
            push   = 1'b1;
            done_d = 1'b1;
            src_d  = rsrc_q;
            if (cnt_inc == rlen_q) begin
              len_d = rlen_q;
              err_d = csum_bad;
            end else begin
              len_d = cnt_inc;
              err_d = 1'b1;
            end
          end else if (ftype == FT_HEAD) begin
            done_d = 1'b1;
            src_d  = rsrc_q;
            len_d  = cnt_q;
            err_d  = 1'b1;
          end
        end
        ST_DROP: begin
          if (ftype == FT_TAIL) begin
            done_d = 1'b1;
            src_d  = rsrc_q;
            len_d  = '0;
            err_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsrc_q <= '0;
      rlen_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      src_q  <= '0;
      len_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      rsrc_q <= rsrc_d;
      rlen_q <= rlen_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      src_q  <= src_d;
      len_q  <= len_d;
      err_q  <= err_d;
    end
  end

`ifdef NOC_EJECT_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_exp_q, csum_exp_d, csum_acc_q, csum_acc_d;

  always_comb begin
    csum_exp_d = csum_exp_q;
    csum_acc_d = csum_acc_q;
    if (accept && state_q == ST_IDLE && ftype == FT_HEAD) begin
      csum_exp_d = in_flit[CSUM_HI:CSUM_LO];
      csum_acc_d = '0;
    end else if (push) begin
      csum_acc_d = csum_acc_q ^ f_pay[CSUM_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      csum_exp_q <= '0;
      csum_acc_q <= '0;
    end else begin
      csum_exp_q <= csum_exp_d;
      csum_acc_q <= csum_acc_d;
    end
  end

  // The tail's own payload is folded in combinationally when the verdict is taken.
  assign csum_bad = ((csum_acc_q ^ f_pay[CSUM_W-1:0]) != csum_exp_q);
`else
  assign csum_bad = 1'b0;
`endif

  noc_sync_fifo #(
    .WIDTH (PAYLOAD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (rx_ready),
    .wdata (f_pay),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rx_valid = !fifo_empty;
  assign pkt_done = done_q;
  assign pkt_src  = src_q;
  assign pkt_len  = len_q;
  assign pkt_err  = err_q;
  assign ready    = (state_q == ST_IDLE) && (fifo_count == '0);

endmodule

// File: tb/tb_noc_eject_unit.sv
// Directed bench for noc_eject_unit (NODE_ID=2, FIFO_DEPTH=4): per-cycle vector table plus handshake sequences.
module tb_noc_eject_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        pkt_done;
  logic [1:0]  pkt_src;
  logic [3:0]  pkt_len;
  logic        pkt_err;
  logic        ready;

  int errors = 0;
  int checks = 0;

  noc_eject_unit #(
    .NODE_ID    (2),
    .FLIT_W     (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_flit  (in_flit),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .pkt_done (pkt_done),
    .pkt_src  (pkt_src),
    .pkt_len  (pkt_len),
    .pkt_err  (pkt_err),
    .ready    (ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] flit;
    logic        vld;
    logic        rr;
    logic        e_rxv;
    logic [13:0] e_rxd;
    logic        e_done;
    logic [1:0]  e_src;
    logic [3:0]  e_len;
    logic        e_err;
    logic        e_rdy;
    logic        e_inr;
  } vec_t;

  vec_t vecs[$];

  logic [15:0] tx_q[$];
  logic [13:0] exp_q[$];
  int          tx_idx, rx_idx, done_cnt;
  logic [1:0]  done_src;
  logic [3:0]  done_len;
  logic        done_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] f, input logic v, input logic rr, input logic rxv,
                     input logic [13:0] rxd, input logic dn, input logic [1:0] s,
                     input logic [3:0] l, input logic e, input logic rdy, input logic inr);
    vec_t t;
    t = '{f, v, rr, rxv, rxd, dn, s, l, e, rdy, inr};
    vecs.push_back(t);
  endtask

  // One handshake cycle: drive next queued flit, sample at negedge, advance at posedge+1.
  task automatic cycle_io(input logic rr);
    rx_ready = rr;
    in_valid = (tx_idx < tx_q.size());
    in_flit  = in_valid ? tx_q[tx_idx] : 16'h0000;
    @(negedge clock);
    if (pkt_done) begin
      done_cnt++;
      done_src = pkt_src;
      done_len = pkt_len;
      done_err = pkt_err;
    end
    if (rx_valid && rx_ready) begin
      if (rx_idx < exp_q.size())
        check($sformatf("rx_order%0d", rx_idx), {18'h0, rx_data}, {18'h0, exp_q[rx_idx]});
      else
        check("rx_extra", {18'h0, rx_data}, 32'hFFFF_FFFF);
      $display("rx %0d data=%h", rx_idx, rx_data);
      rx_idx++;
    end
    if (in_valid && in_ready) tx_idx++;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_stream();
    tx_idx   = 0;
    rx_idx   = 0;
    done_cnt = 0;
    done_src = '0;
    done_len = '0;
    done_err = 1'b0;
  endtask

  initial begin
    logic [24:0] act_p, exp_p;
    int          guard;

    // Packet 1: src1 -> dst2 len3, clean.
    add(16'h58C0, 1, 1, 0, 14'h0000, 0, 2'd0, 4'd0, 0, 0, 1);
    add(16'h8011, 1, 1, 1, 14'h0011, 0, 2'd0, 4'd0, 0, 0, 1);
    add(16'h8022, 1, 1, 1, 14'h0022, 0, 2'd0, 4'd0, 0, 0, 1);
    add(16'hC033, 1, 1, 1, 14'h0033, 1, 2'd1, 4'd3, 0, 0, 1);
    add(16'h0000, 0, 1, 0, 14'h0000, 0, 2'd1, 4'd3, 0, 1, 1);
    // Packet to dst3: dropped, in_ready stays high.
    add(16'h4C80, 1, 1, 0, 14'h0000, 0, 2'd1, 4'd3, 0, 0, 1);
    add(16'h8055, 1, 1, 0, 14'h0000, 0, 2'd1, 4'd3, 0, 0, 1);
    add(16'hC066, 1, 1, 0, 14'h0000, 1, 2'd0, 4'd0, 1, 1, 1);
    add(16'h0000, 0, 1, 0, 14'h0000, 0, 2'd0, 4'd0, 1, 1, 1);
    // Early tail: len3 but only 2 payloads.
    add(16'h78C0, 1, 1, 0, 14'h0000, 0, 2'd0, 4'd0, 1, 0, 1);
    add(16'h8101, 1, 1, 1, 14'h0101, 0, 2'd0, 4'd0, 1, 0, 1);
    add(16'hC202, 1, 1, 1, 14'h0202, 1, 2'd3, 4'd2, 1, 0, 1);
    add(16'h0000, 0, 1, 0, 14'h0000, 0, 2'd3, 4'd2, 1, 1, 1);
    // Following clean len1 packet, all-ones payload.
    add(16'h4840, 1, 1, 0, 14'h0000, 0, 2'd3, 4'd2, 1, 0, 1);
    add(16'hFFFF, 1, 1, 1, 14'h3FFF, 1, 2'd0, 4'd1, 0, 0, 1);
    add(16'h0000, 0, 1, 0, 14'h0000, 0, 2'd0, 4'd1, 0, 1, 1);
    // Head-only packets (hit, then miss) and stray body/tail in IDLE.
    add(16'h5800, 1, 1, 0, 14'h0000, 1, 2'd1, 4'd0, 0, 1, 1);
    add(16'h8AAA, 1, 1, 0, 14'h0000, 0, 2'd1, 4'd0, 0, 1, 1);
    add(16'hC123, 1, 1, 0, 14'h0000, 0, 2'd1, 4'd0, 0, 1, 1);
    add(16'h6000, 1, 1, 0, 14'h0000, 1, 2'd2, 4'd0, 1, 1, 1);
    add(16'h0000, 0, 1, 0, 14'h0000, 0, 2'd2, 4'd0, 1, 1, 1);
    // Extra body at cnt+1==len pushes into DROP.
    add(16'h5840, 1, 1, 0, 14'h0000, 0, 2'd2, 4'd0, 1, 0, 1);
    add(16'h8001, 1, 1, 0, 14'h0000, 0, 2'd2, 4'd0, 1, 0, 1);
    add(16'hC002, 1, 1, 0, 14'h0000, 1, 2'd1, 4'd0, 1, 1, 1);
    add(16'h0000, 0, 1, 0, 14'h0000, 0, 2'd1, 4'd0, 1, 1, 1);

    reset    = 1'b1;
    in_flit  = 16'h0000;
    in_valid = 1'b0;
    rx_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", {25'h0, in_ready, rx_valid, pkt_done, pkt_src, pkt_len, pkt_err, ready},
          {25'h0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1});
    reset = 1'b0;
    @(posedge clock);
    #1;

    foreach (vecs[i]) begin
      in_flit  = vecs[i].flit;
      in_valid = vecs[i].vld;
      rx_ready = vecs[i].rr;
      @(posedge clock);
      #1;
      act_p = {rx_valid, vecs[i].e_rxv ? rx_data : 14'h0000, pkt_done, pkt_src, pkt_len,
               pkt_err, ready, in_ready};
      exp_p = {vecs[i].e_rxv, vecs[i].e_rxd, vecs[i].e_done, vecs[i].e_src, vecs[i].e_len,
               vecs[i].e_err, vecs[i].e_rdy, vecs[i].e_inr};
      $display("vec %0d flit=%h rxv=%b rxd=%h done=%b src=%0d len=%0d err=%b rdy=%b", i,
               vecs[i].flit, rx_valid, rx_data, pkt_done, pkt_src, pkt_len, pkt_err, ready);
      check($sformatf("vec%0d", i), {7'h0, act_p}, {7'h0, exp_p});
    end
    in_valid = 1'b0;

    // Backpressure: len6 with rx_ready low; FIFO fills after 4 payloads.
    clear_stream();
    tx_q  = '{16'h5980, 16'h8001, 16'h8002, 16'h8003, 16'h8004, 16'h8005, 16'hC006};
    exp_q = '{14'h0001, 14'h0002, 14'h0003, 14'h0004, 14'h0005, 14'h0006};
    repeat (8) cycle_io(1'b0);
    check("bp_accepted", tx_idx, 5);
    check("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
    check("bp_rx_valid", {31'h0, rx_valid}, 32'h1);
    guard = 0;
    while ((tx_idx < 7 || rx_idx < 6) && guard < 40) begin
      cycle_io(1'b1);
      guard++;
    end
    check("bp_timeout", {31'h0, guard >= 40}, 32'h0);
    repeat (2) cycle_io(1'b1);
    check("bp_rx_count", rx_idx, 6);
    check("bp_done", {done_cnt[7:0], 2'b0, done_src, done_len, 3'b0, done_err},
          {8'd1, 2'b0, 2'd1, 4'd6, 3'b0, 1'b0});

    // Reset after 2 of 4 payloads; partial packet and FIFO contents must vanish.
    clear_stream();
    tx_q  = '{16'h6900, 16'h8A01, 16'h8A02};
    exp_q = '{};
    repeat (3) cycle_io(1'b0);
    check("rst_pre_accepted", tx_idx, 3);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_state", {25'h0, in_ready, rx_valid, pkt_done, pkt_src, pkt_len, pkt_err, ready},
          {25'h0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1});
    clear_stream();
    tx_q = '{};
    repeat (2) cycle_io(1'b1);
    check("rst_no_done", done_cnt, 0);
    check("rst_no_rx", rx_idx, 0);

    clear_stream();
    tx_q  = '{16'h7880, 16'h8B01, 16'hCB02};
    exp_q = '{14'h0B01, 14'h0B02};
    guard = 0;
    while ((tx_idx < 3 || rx_idx < 2) && guard < 20) begin
      cycle_io(1'b1);
      guard++;
    end
    check("post_rst_timeout", {31'h0, guard >= 20}, 32'h0);
    repeat (2) cycle_io(1'b1);
    check("post_rst_rx_count", rx_idx, 2);
    check("post_rst_done", {done_cnt[7:0], 2'b0, done_src, done_len, 3'b0, done_err},
          {8'd1, 2'b0, 2'd3, 4'd2, 3'b0, 1'b0});
    check("post_rst_ready", {31'h0, ready}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
